cmd_packet_tx: RTL and testbench
================================

# cmd_packet_tx

Host-side packet transmitter for the pulse generator's serial command link. It accepts one 32-bit parameter word and one control byte, then serializes them as 8N1 UART frames in the order the pulse generator's command receiver expects: four data bytes LSB-first, then the control byte. It runs on the 12 MHz base clock. It is used in test harnesses and in the loopback/bring-up design to drive `RS232_Rx` of the pulse generator.

## Interface
Parameters:
- `CLK_DIV`, default 104: clock cycles per bit (12 MHz / 115200 ≈ 104). Legal range 2..65535.
- `GAP_BITS`, default 1: extra idle (high) bit times inserted after each stop bit. Legal range 0..15.

Ports:
- `clk`  input  1  base clock (12 MHz)
- `rst`  input  1  reset, asynchronous, active-high
- `start`  input  1  request to send one packet; sampled when `busy`=0
- `data`  input  32  parameter word (delay/period/width/attenuator field)
- `ctrl`  input  8  control byte (0=delay, 1=period, 2=pump, 3=probe, 4=toggle pump, 5=att, 6=read test); passed through unchecked
- `tx`  output  1  serial line; idles high
- `busy`  output  1  high from acceptance until the packet completes
- `done`  output  1  one-cycle pulse at packet completion

## Operation
- States: IDLE, START_BIT, DATA_BITS, STOP_BIT, GAP, FINISH.
- IDLE: `tx`=1. When `start`=1, capture `data` and `ctrl` into internal registers, set byte index 0, set `busy`=1, and go to START_BIT.
- Byte sequence is `data[7:0]`, `data[15:8]`, `data[23:16]`, `data[31:24]`, then `ctrl`, plus the checksum byte if it is enabled.
- START_BIT: `tx`=0 for CLK_DIV cycles.
- DATA_BITS: 8 bits, LSB first, each held CLK_DIV cycles.
- STOP_BIT: `tx`=1 for CLK_DIV cycles.
- GAP: `tx`=1 for GAP_BITS×CLK_DIV cycles. This state is skipped when GAP_BITS=0.
- After STOP/GAP:
  - If more bytes remain, increment the index and go to START_BIT.
  - Otherwise go to FINISH.
- FINISH: lasts one cycle. `done`=1, `busy`=0, then return to IDLE.
- Bit timer is a 16-bit down-counter, reloaded to CLK_DIV−1 at each bit boundary. The bit counter is 3 bits and the byte index is 3 bits.
- Inputs are captured only at acceptance. Later changes to `data`/`ctrl` do not affect a packet in flight.
- `start` while `busy`=1 is ignored and is not queued.
- `start` held high continuously produces back-to-back packets: each is accepted in the IDLE cycle after FINISH.
- Reset mid-packet: everything returns to reset values immediately. The truncated frame is abandoned. The next accepted packet restarts at byte 0.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, state IDLE.
- `tx`, `busy` and `done` are registered; there is no combinational path from inputs to outputs.
- `start` is accepted at clock edge N. From edge N, `busy`=1 and `tx`=0 (start bit begins).
- Byte k's start bit begins at edge N + k×(10+GAP_BITS)×CLK_DIV.
- Let B = number of bytes: 5, or 6 with the checksum.
- `done`=1 and `busy`=0 at edge N + B×(10+GAP_BITS)×CLK_DIV. This cycle is FINISH.
- The earliest next acceptance is at the following edge. Minimum packet-to-packet period is B×(10+GAP_BITS)×CLK_DIV + 1 cycles.
- Bit period error is zero in clock cycles. Baud accuracy depends only on the choice of CLK_DIV.

## Configuration
- `CMD_PACKET_TX_CHECKSUM_EN` defined:
  - A sixth byte is sent after `ctrl`.
  - Its value is (`data[31:24]`+`data[23:16]`+`data[15:8]`+`data[7:0]`) mod 256, computed at acceptance.
  - B=6.
- Not defined: no checksum logic is present and B=5.

## Test plan
- CLK_DIV=4, GAP_BITS=0, `data`=32'h000007D0, `ctrl`=8'h00, one `start` pulse:
  - Decoded bytes are D0, 07, 00, 00, 00, each LSB-first with start=0 and stop=1.
  - `done` pulses exactly 200 cycles after acceptance. With the checksum enabled, a sixth byte D7 follows and `done` is at 240 cycles.
- CLK_DIV=4, GAP_BITS=1, `data`=32'h001E8480, `ctrl`=8'h01:
  - Bytes are 80, 84, 1E, 00, 01.
  - Each byte starts 44 cycles after the previous one.
  - `done` at 220 cycles.
- `start` re-pulsed at cycle 50 of a packet in flight, with different `data`:
  - The packet in flight is unchanged.
  - No second packet is sent.
  - `done` pulses exactly once.
- `start` held high, two packets, with `data` changed between them:
  - The second start bit begins exactly 1 cycle after the first `done`.
  - The second packet carries the new `data`.
- `rst` asserted asynchronously mid-bit during byte 2:
  - `tx`=1, `busy`=0, `done`=0 immediately, with no clock edge needed.
  - After release, a new packet sends byte 0 first and completes normally.
- Loopback of `tx` into the codebase's UART receiver (12 MHz, CLK_DIV=104), `ctrl`=8'h05, `data`=32'h01000A14:
  - The receiver reports bytes 14, 0A, 00, 01, 05 with `recv_error` never asserted.

Source files
------------

// File: rtl/cmd_packet_tx.sv
// Purpose : serializes one 32-bit parameter word plus a control byte as 8N1 UART frames
//           (data[7:0], data[15:8], data[23:16], data[31:24], ctrl [, checksum]).
// Latency : tx start bit begins on the accepting edge; done pulses B*(10+GAP_BITS)*CLK_DIV
//           cycles later.
// Backpressure: start is only sampled while busy=0; a start during a packet is dropped.
//
// Ports:
//   clk   - base clock (12 MHz)
//   rst   - asynchronous active-high reset
//   start - request one packet (sampled when busy=0)
//   data  - 32-bit parameter word, captured at acceptance
//   ctrl  - control byte, captured at acceptance, passed through unchecked
//   tx    - serial line, idles high
//   busy  - high from acceptance until packet completion
//   done  - one-cycle pulse at packet completion
//
// Optional feature: define CMD_PACKET_TX_CHECKSUM_EN to append a sixth byte holding
// the mod-256 sum of the four data bytes.

module cmd_packet_tx #(
    parameter int CLK_DIV  = 104,
    parameter int GAP_BITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] data,
    input  logic [7:0]  ctrl,
    output logic        tx,
    output logic        busy,
    output logic        done
);

`ifdef CMD_PACKET_TX_CHECKSUM_EN
    localparam int NBYTES = 6;
`else
    localparam int NBYTES = 5;
`endif

    localparam logic [2:0]  LAST_IDX   = 3'(NBYTES - 1);
    localparam logic [15:0] BIT_RELOAD = 16'(CLK_DIV - 1);
    localparam logic [3:0]  GAP_RELOAD = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        GAP,
        FINISH
    } state_t;

    state_t      state;
    logic [15:0] bit_timer;
    logic [2:0]  bit_cnt;
    logic [2:0]  byte_idx;
    logic [3:0]  gap_cnt;
    logic [31:0] data_q;
    logic [7:0]  ctrl_q;
    logic [7:0]  cur_byte;
    logic        byte_end;

`ifdef CMD_PACKET_TX_CHECKSUM_EN
    logic [7:0] cksum_q;
    logic [7:0] cksum_next;

    always_comb begin
        cksum_next = data[31:24] + data[23:16] + data[15:8] + data[7:0];
    end
`endif

    // Byte currently on the wire, selected by the byte index.
    always_comb begin
        cur_byte = ctrl_q;
        case (byte_idx)
            3'd0:    cur_byte = data_q[7:0];
            3'd1:    cur_byte = data_q[15:8];
            3'd2:    cur_byte = data_q[23:16];
            3'd3:    cur_byte = data_q[31:24];
            3'd4:    cur_byte = ctrl_q;
`ifdef CMD_PACKET_TX_CHECKSUM_EN
            3'd5:    cur_byte = cksum_q;
`endif
            default: cur_byte = ctrl_q;
        endcase
    end

    // Last cycle of a byte's trailing idle time: end of stop bit when there is no
    // gap, otherwise end of the final gap bit.
    always_comb begin
        byte_end = 1'b0;
        if (bit_timer == 16'd0) begin
            if (state == STOP_BIT && GAP_BITS == 0)
                byte_end = 1'b1;
            else if (state == GAP && gap_cnt == 4'd0)
                byte_end = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            bit_timer <= 16'd0;
            bit_cnt   <= 3'd0;
            byte_idx  <= 3'd0;
            gap_cnt   <= 4'd0;
            data_q    <= 32'd0;
            ctrl_q    <= 8'd0;
`ifdef CMD_PACKET_TX_CHECKSUM_EN
            cksum_q   <= 8'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                // FINISH accepts like IDLE so a held start gives back-to-back packets
                // with the new start bit one cycle after done.
                IDLE, FINISH: begin
                    state <= IDLE;
                    if (start) begin
                        state     <= START_BIT;
                        tx        <= 1'b0;
                        busy      <= 1'b1;
                        bit_timer <= BIT_RELOAD;
                        bit_cnt   <= 3'd0;
                        byte_idx  <= 3'd0;
                        data_q    <= data;
                        ctrl_q    <= ctrl;
`ifdef CMD_PACKET_TX_CHECKSUM_EN
                        cksum_q   <= cksum_next;
`endif
                    end
                end

                START_BIT: begin
                    if (bit_timer == 16'd0) begin
                        state     <= DATA_BITS;
                        tx        <= cur_byte[0];
                        bit_timer <= BIT_RELOAD;
                        bit_cnt   <= 3'd0;
                    end else begin
                        bit_timer <= bit_timer - 16'd1;
                    end
                end

                DATA_BITS: begin
                    if (bit_timer == 16'd0) begin
                        bit_timer <= BIT_RELOAD;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP_BIT;
                            tx    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= cur_byte[3'(bit_cnt + 3'd1)];
                        end
                    end else begin
                        bit_timer <= bit_timer - 16'd1;
                    end
                end

                STOP_BIT, GAP: begin
                    if (byte_end) begin
                        if (byte_idx == LAST_IDX) begin
                            state <= FINISH;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state     <= START_BIT;
                            tx        <= 1'b0;
                            byte_idx  <= byte_idx + 3'd1;
                            bit_timer <= BIT_RELOAD;
                        end
                    end else if (bit_timer == 16'd0) begin
                        // Stop bit finished with gap configured, or another gap bit follows.
                        bit_timer <= BIT_RELOAD;
                        if (state == STOP_BIT) begin
                            state   <= GAP;
                            gap_cnt <= GAP_RELOAD;
                        end else begin
                            gap_cnt <= gap_cnt - 4'd1;
                        end
                    end else begin
                        bit_timer <= bit_timer - 16'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_packet_tx.sv
`timescale 1ns/1ps

module tb_cmd_packet_tx;

`ifdef CMD_PACKET_TX_CHECKSUM_EN
    localparam int NB = 6;
`else
    localparam int NB = 5;
`endif

    typedef struct {
        logic [7:0] val;
        int         t;
    } exp_byte_t;

    logic        clk;
    logic        rst;
    logic [2:0]  start_v;
    logic [31:0] data;
    logic [7:0]  ctrl;
    logic [2:0]  tx_v, busy_v, done_v;
    logic [1:0]  sel;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    // per-instance bit period and byte period (10+GAP)*CLK_DIV
    int d_tab [3] = '{4, 4, 104};
    int p_tab [3] = '{40, 44, 1144};

    exp_byte_t exp_q[$];
    int        done_q[$];

    cmd_packet_tx #(.CLK_DIV(4), .GAP_BITS(0)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .data(data), .ctrl(ctrl),
        .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
    cmd_packet_tx #(.CLK_DIV(4), .GAP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .data(data), .ctrl(ctrl),
        .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
    cmd_packet_tx #(.CLK_DIV(104), .GAP_BITS(1)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .data(data), .ctrl(ctrl),
        .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    logic mtx, mbusy, mdone;
    assign mtx   = tx_v[sel];
    assign mbusy = busy_v[sel];
    assign mdone = done_v[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // ---------------- monitor: UART frame decoder + done checker ----------------
    int         mon_off, mon_start, half, bit_j;
    logic       mon_act = 1'b0;
    logic       mon_ok;
    logic [7:0] mon_byte;

    always @(negedge clk) begin
        if (rst) begin
            mon_act = 1'b0;
        end else begin
            if (mdone) begin
                if (done_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_done actual=cycle %0d expected=none", cyc);
                end else begin
                    chk("done_cycle", cyc, done_q.pop_front());
                end
            end
            if (!mon_act) begin
                if (mtx == 1'b0) begin
                    mon_act   = 1'b1;
                    mon_off   = 0;
                    mon_start = cyc;
                    mon_ok    = 1'b1;
                end
            end else begin
                mon_off++;
            end
            half = d_tab[sel] / 2;
            if (mon_act && mon_off >= half && ((mon_off - half) % d_tab[sel]) == 0) begin
                bit_j = (mon_off - half) / d_tab[sel];
                if (bit_j == 0) begin
                    if (mtx !== 1'b0) mon_ok = 1'b0;
                end else if (bit_j <= 8) begin
                    mon_byte[bit_j-1] = mtx;
                end else begin
                    if (mtx !== 1'b1) mon_ok = 1'b0;
                    mon_act = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL extra_byte actual=%0h expected=none", mon_byte);
                    end else begin
                        exp_byte_t e;
                        e = exp_q.pop_front();
                        chk("byte_value", mon_byte, e.val);
                        chk("byte_start_cycle", mon_start, e.t);
                        chk("byte_framing", mon_ok, 1);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_pkt(input int s, input logic [47:0] eb, input int acc);
        for (int k = 0; k < NB; k++) begin
            exp_byte_t e;
            e.val = eb[k*8 +: 8];
            e.t   = acc + k * p_tab[s];
            exp_q.push_back(e);
        end
        done_q.push_back(acc + NB * p_tab[s]);
    endtask

    task automatic send(input logic [1:0] s, input logic [31:0] d, input logic [7:0] c,
                        input logic [47:0] eb, output int acc);
        sel  = s;
        data = d;
        ctrl = c;
        @(negedge clk);
        start_v[s] = 1'b1;
        @(negedge clk);
        start_v[s] = 1'b0;
        acc = cyc;
        chk("accept_busy", mbusy, 1);
        chk("accept_tx_low", mtx, 0);
        push_pkt(s, eb, acc);
    endtask

    task automatic wait_idle(output int fin);
        int n;
        n = 0;
        while (mbusy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (mbusy) begin
            checks++; errors++;
            $display("FAIL busy_timeout actual=busy expected=idle");
        end
        fin = cyc;
    endtask

    initial begin
        int acc, fin, acc1;
        rst = 1'b1; start_v = 3'b000; sel = 2'd0; data = 32'd0; ctrl = 8'd0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset_tx", tx_v[i], 1);
            chk("reset_busy", busy_v[i], 0);
            chk("reset_done", done_v[i], 0);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // T1: CLK_DIV=4, GAP=0
        send(2'd0, 32'h000007D0, 8'h00, 48'hD7_00_00_00_07_D0, acc);
        wait_idle(fin);
        chk("t1_done_latency", fin - acc, (NB == 6) ? 240 : 200);
        repeat (5) @(negedge clk);

        // T2: CLK_DIV=4, GAP=1
        send(2'd1, 32'h001E8480, 8'h01, 48'h22_01_00_1E_84_80, acc);
        wait_idle(fin);
        chk("t2_done_latency", fin - acc, (NB == 6) ? 264 : 220);
        repeat (5) @(negedge clk);

        // T3: start re-pulsed mid-packet with different data
        send(2'd1, 32'hDEADBEEF, 8'h06, 48'h38_06_DE_AD_BE_EF, acc);
        repeat (49) @(negedge clk);
        data = 32'h11111111;
        ctrl = 8'h03;
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        wait_idle(fin);
        repeat (300) @(negedge clk);
        chk("t3_no_second_packet", mbusy, 0);

        // T4: start held high, back-to-back packets with new data
        sel = 2'd0;
        data = 32'h12345678;
        ctrl = 8'h02;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        acc1 = cyc;
        chk("t4_accept_busy", mbusy, 1);
        push_pkt(0, 48'h14_02_12_34_56_78, acc1);
        data = 32'hA5A50F0F;
        ctrl = 8'h03;
        push_pkt(0, 48'h68_03_A5_A5_0F_0F, acc1 + NB * 40 + 1);
        repeat (NB * 40 + 1) @(negedge clk);
        chk("t4_b2b_busy", mbusy, 1);
        chk("t4_b2b_tx_low", mtx, 0);
        start_v[0] = 1'b0;
        wait_idle(fin);
        repeat (5) @(negedge clk);

        // T5: async reset mid-bit in byte 2
        send(2'd0, 32'hCAFEF00D, 8'h04, 48'hC5_04_CA_FE_F0_0D, acc);
        repeat (2 * 40 + 13) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_tx", mtx, 1);
        chk("t5_rst_busy", mbusy, 0);
        chk("t5_rst_done", mdone, 0);
        exp_q.delete();
        done_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // T6: after reset, packet restarts at byte 0
        send(2'd0, 32'h000007D0, 8'h00, 48'hD7_00_00_00_07_D0, acc);
        wait_idle(fin);
        repeat (5) @(negedge clk);

        // T7: baud-rate instance, CLK_DIV=104
        send(2'd2, 32'h01000A14, 8'h05, 48'h1F_05_01_00_0A_14, acc);
        wait_idle(fin);
        repeat (20) @(negedge clk);

        chk("exp_bytes_outstanding", exp_q.size(), 0);
        chk("exp_done_outstanding", done_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
